// File: rtl/module_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multi-cycle mul/div sequencer.
interface module_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] res;

  modport master (output start, flush, op, op1, op2, input busy, valid, res);
  modport slave  (input start, flush, op, op1, op2, output busy, valid, res);
endinterface

// File: rtl/module_muldiv_seq.sv
// RV32M sequencer: shift-add multiply / restoring divide, one bit per clock, fixed latency.
module module_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  module_muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] ADD = 2'd1;
  localparam logic [1:0] SUB = 2'd2;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, nextState;
  logic [2:0]      opReg;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] accHi, accLo, operandB, resReg;
  logic            negRes;

  logic            capture, isMul, signed1, signed2, neg1, neg2, capNeg;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   remShift, addA, addB, addSum;
  logic [1:0]      addCtrl;
  logic            trialOk;
  logic [2*XLEN-1:0] prodSigned;
  logic [XLEN-1:0] quoSigned, remSigned, fixRes;

  assign capture   = bus.start && !bus.flush && (state == IDLE || state == DONE);
  assign bus.busy  = (state == CALC) || (state == FIX);
  assign bus.valid = (state == DONE);
  assign bus.res   = resReg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (bus.flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) nextState = CALC;
        CALC:    if (cnt == '0) nextState = FIX;
        FIX:     nextState = DONE;
        DONE:    nextState = bus.start ? CALC : IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Work on magnitudes; the sign is reapplied in FIX. A zero divisor forces a positive quotient
  // so the restoring loop's natural all-ones quotient survives for DIV too.
  always_comb begin
    isMul   = !bus.op[2];
    signed1 = bus.op inside {3'd1, 3'd2, 3'd4, 3'd6};
    signed2 = bus.op inside {3'd1, 3'd4, 3'd6};
    neg1    = signed1 && bus.op1[XLEN-1];
    neg2    = signed2 && bus.op2[XLEN-1];
    abs1    = neg1 ? -bus.op1 : bus.op1;
    abs2    = neg2 ? -bus.op2 : bus.op2;
    if (isMul)          capNeg = neg1 ^ neg2;
    else if (bus.op[1]) capNeg = neg1;
    else                capNeg = (bus.op2 != '0) && (neg1 ^ neg2);
  end

  assign remShift = {accHi, accLo[XLEN-1]};

  // Shared XLEN+1-bit adder: accumulate for multiply, trial subtract for divide.
  always_comb begin
    addA    = {1'b0, accHi};
    addB    = {1'b0, operandB};
    addCtrl = accLo[0] ? ADD : 2'd0;
    if (opReg[2]) begin
      addA    = remShift;
      addCtrl = SUB;
    end
    case (addCtrl)
      ADD:     addSum = addA + addB;
      SUB:     addSum = addA - addB;
      default: addSum = addA;
    endcase
    trialOk = !addSum[XLEN];
  end

  always_comb begin
    prodSigned = negRes ? -{accHi, accLo} : {accHi, accLo};
    quoSigned  = negRes ? -accLo : accLo;
    remSigned  = negRes ? -accHi : accHi;
    case (opReg)
      3'd0:               fixRes = prodSigned[XLEN-1:0];
      3'd1, 3'd2, 3'd3:   fixRes = prodSigned[2*XLEN-1:XLEN];
      3'd4, 3'd5:         fixRes = quoSigned;
      default:            fixRes = remSigned;
    endcase
  end

  // Multiply keeps the multiplier in accLo and shifts the product in from the top;
  // divide keeps the remainder in accHi and shifts quotient bits into accLo.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opReg    <= '0;
      cnt      <= '0;
      accHi    <= '0;
      accLo    <= '0;
      operandB <= '0;
      negRes   <= 1'b0;
      resReg   <= '0;
    end else if (capture) begin
      opReg    <= bus.op;
      operandB <= isMul ? abs1 : abs2;
      accLo    <= isMul ? abs2 : abs1;
      accHi    <= '0;
      negRes   <= capNeg;
      cnt      <= CW'(XLEN - 1);
    end else if (state == CALC && !bus.flush) begin
      if (opReg[2]) begin
        accHi <= trialOk ? addSum[XLEN-1:0] : remShift[XLEN-1:0];
        accLo <= {accLo[XLEN-2:0], trialOk};
      end else begin
        accHi <= addSum[XLEN:1];
        accLo <= {addSum[0], accLo[XLEN-1:1]};
      end
      cnt <= cnt - 1'b1;
    end else if (state == FIX && !bus.flush) begin
      resReg <= fixRes;
    end
  end
endmodule

// File: tb/tb_module_muldiv_seq.sv
// Scoreboard bench for module_muldiv_seq: arithmetic reference model, random and directed ops.
module tb_module_muldiv_seq;
  localparam int XLEN    = 32;
  localparam int LATENCY = XLEN + 2;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
    int          issueCycle;
  } expect_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cycle = 0;
  int   checkCount = 0;
  int   passCount = 0;
  logic prevValid = 1'b0;
  expect_t sbQueue[$];

  module_muldiv_seq_if #(.XLEN(XLEN)) bus();

  module_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // RV32M semantics straight from the ISA rules, using 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    logic [63:0] p;
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 50));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checkCount++;
    if (actual === required) passCount++;
    else $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, required);
  endtask

  // Waits out any operation in flight (DONE counts as free, so successive calls run back-to-back).
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
    int waitCount = 0;
    @(negedge clk);
    while (bus.busy && waitCount < 200) begin
      @(negedge clk);
      waitCount++;
    end
    if (waitCount >= 200) checkOutput("stimulus_wait_timeout", 32'(waitCount), 32'd0);
    bus.op    = op;
    bus.op1   = a;
    bus.op2   = b;
    bus.start = 1'b1;
    if (track) sbQueue.push_back('{op, a, b, refModel(op, a, b), cycle});
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sbQueue.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput("drain_timeout", 32'(sbQueue.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding request, in value and latency.
  always @(negedge clk) begin
    expect_t e;
    if (bus.valid) begin
      checkOutput("valid_pulse_width", {31'b0, prevValid}, 32'd0);
      checkOutput("scoreboard_has_entry", {31'b0, sbQueue.size() != 0}, 32'd1);
      if (sbQueue.size() != 0) begin
        e = sbQueue.pop_front();
        checkOutput($sformatf("res op%0d a=%08h b=%08h", e.op, e.a, e.b), bus.res, e.expected);
        checkOutput($sformatf("latency op%0d", e.op), 32'(cycle - e.issueCycle), 32'(LATENCY));
      end
    end
    prevValid = bus.valid;
  end

  initial begin
    vec_t directed[$];
    int   validCount;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'd0;
    bus.op1   = '0;
    bus.op2   = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",  {31'b0, bus.busy},  32'd0);
    checkOutput("reset_valid", {31'b0, bus.valid}, 32'd0);
    checkOutput("reset_res",   bus.res,            32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    directed = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD},
      '{3'd1, 32'h8000_0000,  32'h8000_0000},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
      '{3'd2, 32'hFFFF_FFFF,  32'd2},
      '{3'd4, 32'hFFFF_FFEB,  32'd5},
      '{3'd6, 32'hFFFF_FFEB,  32'd5},
      '{3'd5, 32'd100,        32'd7},
      '{3'd7, 32'd100,        32'd7},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF},
      '{3'd5, 32'd9,          32'd0},
      '{3'd7, 32'd9,          32'd0},
      '{3'd4, 32'hFFFF_FFF7,  32'd0},
      '{3'd6, 32'hFFFF_FFF7,  32'd0}
    };
    foreach (directed[i]) applyStimulus(directed[i].op, directed[i].a, directed[i].b, 1'b1);
    waitDrain();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), 1'b1);
    end
    waitDrain();

    // A start while busy must not disturb the op in flight.
    applyStimulus(3'd0, 32'd3, 32'd4, 1'b1);
    repeat (4) @(negedge clk);
    bus.op    = 3'd4;
    bus.op1   = 32'd100;
    bus.op2   = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitDrain();
    checkOutput("ignored_start_res", bus.res, 32'd12);

    applyStimulus(3'd0, 32'd5, 32'd6, 1'b0);
    repeat (8) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    checkOutput("flush_busy", {31'b0, bus.busy}, 32'd0);
    validCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) validCount++;
    end
    checkOutput("flush_no_valid", 32'(validCount), 32'd0);
    checkOutput("flush_res_kept", bus.res, 32'd12);

    @(negedge clk);
    bus.op    = 3'd0;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checkOutput("flush_beats_start", {31'b0, bus.busy}, 32'd0);

    applyStimulus(3'd4, 32'hFFFF_FFEB, 32'd5, 1'b0);
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midop_reset_busy",  {31'b0, bus.busy},  32'd0);
    checkOutput("midop_reset_valid", {31'b0, bus.valid}, 32'd0);
    checkOutput("midop_reset_res",   bus.res,            32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(3'd0, 32'd2, 32'd2, 1'b1);
    waitDrain();

    checkOutput("scoreboard_empty", 32'(sbQueue.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
